// File: rtl/ldh_mem_sequencer_pkg.sv
// Shared types and constants for the A<->memory transfer microcode sequencer.
// Holds the state encoding, addressing-mode codes and register-select bit positions.
package ldh_mem_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IMM_LO,
        ST_IMM_HI,
        ST_ADDR,
        ST_DATA,
        ST_FETCH
    } state_t;

    localparam logic [1:0] MODE_C   = 2'b00;
    localparam logic [1:0] MODE_A8  = 2'b01;
    localparam logic [1:0] MODE_A16 = 2'b10;

    localparam int REG8_Z_IDX   = 0;
    localparam int REG8_W_IDX   = 1;
    localparam int REG8_C_IDX   = 3;
    localparam int REG16_WZ_IDX = 0;
    localparam int REG16_PC_IDX = 5;

    // The unused mode code 11 behaves as the full 16-bit absolute form.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == 2'b11) ? MODE_A16 : mode;
    endfunction

    function automatic state_t first_state(input logic [1:0] mode);
        return (mode == MODE_C) ? ST_ADDR : ST_IMM_LO;
    endfunction

endpackage

// File: rtl/ldh_step_counter.sv
// T-step counter inside one M-cycle: clear, hold (stall) and wrap on the last step.
module ldh_step_counter #(
    parameter int STEPS  = 4,
    parameter int STEP_W = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Clear,
    input  logic              i_Hold,
    output logic [STEP_W-1:0] o_Step,
    output logic              o_Last_Step
);

    logic [STEP_W-1:0] r_step;

    assign o_Step      = r_step;
    assign o_Last_Step = (r_step == STEP_W'(STEPS - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_step <= '0;
        end else if (i_Clear) begin
            r_step <= '0;
        end else if (!i_Hold) begin
            r_step <= o_Last_Step ? '0 : r_step + 1'b1;
        end
    end

endmodule

// File: rtl/ldh_mem_sequencer.sv
// Self-sequencing microcode for LD (C),A / LDH (a8) / LD (a16) transfers in both directions.
// Strobes are decoded from registered state, step and latched mode/direction only.
module ldh_mem_sequencer
    import ldh_mem_sequencer_pkg::*;
#(
    parameter int STEPS_PER_MCYCLE = 4,
    parameter int REG8_W           = 8,
    parameter int REG16_W          = 6
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Start,
    input  logic [1:0]         i_Mode,
    input  logic               i_Dir,
    input  logic               i_Wait,
    input  logic               i_Flush,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_IR_Fetch,
    output logic [REG8_W-1:0]  o_Read8,
    output logic [REG8_W-1:0]  o_Write8,
    output logic [REG16_W-1:0] o_Read16,
    output logic [REG16_W-1:0] o_Write16,
    output logic [1:0]         o_ReadALU8,
    output logic [1:0]         o_WriteALU8,
    output logic               o_Move_Reg,
    output logic               o_Bus_In,
    output logic               o_Bus_Out,
    output logic               o_Address_Out,
    output logic               o_Bus8_To_Bus16,
    output logic [1:0]         o_Increment16
);

    localparam int STEP_W = $clog2(STEPS_PER_MCYCLE);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_mode;
    logic              r_dir;
    logic              w_latch;
    logic [STEP_W-1:0] w_step;
    logic              w_last;
    logic              w_clear;

    // Step stays pinned at 0 while idle so every instruction begins on step 0.
    assign w_clear = (r_state == ST_IDLE) || i_Flush;

    ldh_step_counter #(
        .STEPS  (STEPS_PER_MCYCLE),
        .STEP_W (STEP_W)
    ) u_step (
        .i_Clk       (i_Clk),
        .i_Rst_n     (i_Rst_n),
        .i_Clear     (w_clear),
        .i_Hold      (i_Wait),
        .o_Step      (w_step),
        .o_Last_Step (w_last)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= 2'b00;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_mode <= norm_mode(i_Mode);
                r_dir  <= i_Dir;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        if (r_state == ST_IDLE) begin
            if (i_Start && !i_Wait) begin
                w_latch      = 1'b1;
                w_state_next = first_state(i_Mode);
            end
        end else if (i_Flush) begin
            w_state_next = ST_IDLE;
        end else if (!i_Wait && w_last) begin
            case (r_state)
                ST_IMM_LO: w_state_next = (r_mode == MODE_A16) ? ST_IMM_HI : ST_ADDR;
                ST_IMM_HI: w_state_next = ST_ADDR;
                ST_ADDR:   w_state_next = ST_DATA;
                ST_DATA:   w_state_next = ST_FETCH;
                ST_FETCH: begin
                    // A start seen on the final fetch step chains straight into the next instruction.
                    if (i_Start) begin
                        w_latch      = 1'b1;
                        w_state_next = first_state(i_Mode);
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_Busy          = (r_state != ST_IDLE);
        o_Done          = 1'b0;
        o_IR_Fetch      = 1'b0;
        o_Read8         = '0;
        o_Write8        = '0;
        o_Read16        = '0;
        o_Write16       = '0;
        o_ReadALU8      = 2'b00;
        o_WriteALU8     = 2'b00;
        o_Move_Reg      = 1'b0;
        o_Bus_In        = 1'b0;
        o_Bus_Out       = 1'b0;
        o_Address_Out   = 1'b0;
        o_Bus8_To_Bus16 = 1'b0;
        o_Increment16   = 2'b00;
        case (r_state)
            ST_IMM_LO, ST_IMM_HI: begin
                if (w_step == '0) begin
                    o_Read16[REG16_PC_IDX] = 1'b1;
                    o_Address_Out          = 1'b1;
                end else if (w_step == STEP_W'(1)) begin
                    o_Increment16[0]        = 1'b1;
                    o_Write16[REG16_PC_IDX] = 1'b1;
                end else if (w_step == STEP_W'(2)) begin
                    o_Bus_In = 1'b1;
                    if (r_state == ST_IMM_LO) o_Write8[REG8_Z_IDX] = 1'b1;
                    else                      o_Write8[REG8_W_IDX] = 1'b1;
                end
            end
            ST_ADDR: begin
                if (w_step == '0) begin
                    o_Address_Out = 1'b1;
                    // 8-bit forms drive the low byte onto the address bus with the FF high page.
                    if (r_mode == MODE_C) begin
                        o_Read8[REG8_C_IDX] = 1'b1;
                        o_Bus8_To_Bus16     = 1'b1;
                    end else if (r_mode == MODE_A8) begin
                        o_Read8[REG8_Z_IDX] = 1'b1;
                        o_Bus8_To_Bus16     = 1'b1;
                    end else begin
                        o_Read16[REG16_WZ_IDX] = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_step == '0) begin
                    if (r_dir) begin
                        o_WriteALU8[0] = 1'b1;
                        o_Bus_In       = 1'b1;
                    end else begin
                        o_ReadALU8[0] = 1'b1;
                        o_Move_Reg    = 1'b1;
                        o_Bus_Out     = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                o_IR_Fetch = 1'b1;
                o_Done     = w_last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldh_mem_sequencer.sv
// Randomized and directed bench for ldh_mem_sequencer against a phase-list reference model.
module tb_ldh_mem_sequencer;

    localparam int STEPS = 4;
    localparam int PH_IMM_LO = 1, PH_IMM_HI = 2, PH_ADDR = 3, PH_DATA = 4, PH_FETCH = 5;

    typedef struct packed {
        logic       busy, done, irf;
        logic [7:0] rd8, wr8;
        logic [5:0] rd16, wr16;
        logic [1:0] ralu, walu;
        logic       move, bin, bout, addr, b816;
        logic [1:0] inc;
    } bundle_t;

    logic       i_Clk = 1'b0;
    logic       i_Rst_n, i_Start, i_Dir, i_Wait, i_Flush;
    logic [1:0] i_Mode;
    logic       o_Busy, o_Done, o_IR_Fetch, o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out, o_Bus8_To_Bus16;
    logic [7:0] o_Read8, o_Write8;
    logic [5:0] o_Read16, o_Write16;
    logic [1:0] o_ReadALU8, o_WriteALU8, o_Increment16;
    bundle_t    dut_b;

    ldh_mem_sequencer #(.STEPS_PER_MCYCLE(STEPS), .REG8_W(8), .REG16_W(6)) dut (
        .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Start(i_Start), .i_Mode(i_Mode), .i_Dir(i_Dir),
        .i_Wait(i_Wait), .i_Flush(i_Flush), .o_Busy(o_Busy), .o_Done(o_Done), .o_IR_Fetch(o_IR_Fetch),
        .o_Read8(o_Read8), .o_Write8(o_Write8), .o_Read16(o_Read16), .o_Write16(o_Write16),
        .o_ReadALU8(o_ReadALU8), .o_WriteALU8(o_WriteALU8), .o_Move_Reg(o_Move_Reg),
        .o_Bus_In(o_Bus_In), .o_Bus_Out(o_Bus_Out), .o_Address_Out(o_Address_Out),
        .o_Bus8_To_Bus16(o_Bus8_To_Bus16), .o_Increment16(o_Increment16)
    );

    assign dut_b = {o_Busy, o_Done, o_IR_Fetch, o_Read8, o_Write8, o_Read16, o_Write16,
                    o_ReadALU8, o_WriteALU8, o_Move_Reg, o_Bus_In, o_Bus_Out, o_Address_Out,
                    o_Bus8_To_Bus16, o_Increment16};

    always #5 i_Clk = ~i_Clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: an instruction is a list of M-cycle phases, each STEPS clocks long.
    bit         m_busy;
    int         m_idx, m_step;
    logic [1:0] m_mode;
    logic       m_dir;
    int         m_seq[$];

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_step = 0; m_mode = 2'b00; m_dir = 1'b0;
        m_seq.delete();
    endtask

    task automatic model_begin(input logic [1:0] md, input logic dr);
        m_busy = 1; m_idx = 0; m_step = 0;
        m_mode = (md == 2'b11) ? 2'b10 : md;
        m_dir  = dr;
        m_seq.delete();
        if (m_mode != 2'b00) m_seq.push_back(PH_IMM_LO);
        if (m_mode == 2'b10) m_seq.push_back(PH_IMM_HI);
        m_seq.push_back(PH_ADDR);
        m_seq.push_back(PH_DATA);
        m_seq.push_back(PH_FETCH);
    endtask

    task automatic model_update(input logic st, input logic [1:0] md, input logic dr,
                                input logic wt, input logic fl);
        if (!i_Rst_n) model_reset();
        else if (!m_busy) begin
            if (st && !wt) model_begin(md, dr);
        end else if (fl) m_busy = 0;
        else if (!wt) begin
            if (m_step == STEPS - 1) begin
                m_step = 0;
                if (m_idx == m_seq.size() - 1) begin
                    if (st) model_begin(md, dr);
                    else    m_busy = 0;
                end else m_idx++;
            end else m_step++;
        end
    endtask

    function automatic bundle_t exp_b();
        bundle_t b;
        int ph;
        b = '0;
        if (!m_busy) return b;
        b.busy = 1'b1;
        ph = m_seq[m_idx];
        if (ph == PH_IMM_LO || ph == PH_IMM_HI) begin
            if (m_step == 0)      begin b.rd16[5] = 1'b1; b.addr = 1'b1; end
            else if (m_step == 1) begin b.inc[0] = 1'b1; b.wr16[5] = 1'b1; end
            else if (m_step == 2) begin b.bin = 1'b1; b.wr8[(ph == PH_IMM_LO) ? 0 : 1] = 1'b1; end
        end else if (ph == PH_ADDR && m_step == 0) begin
            b.addr = 1'b1;
            if (m_mode == 2'b00)      begin b.rd8[3] = 1'b1; b.b816 = 1'b1; end
            else if (m_mode == 2'b01) begin b.rd8[0] = 1'b1; b.b816 = 1'b1; end
            else                      b.rd16[0] = 1'b1;
        end else if (ph == PH_DATA && m_step == 0) begin
            if (m_dir) begin b.walu[0] = 1'b1; b.bin = 1'b1; end
            else       begin b.ralu[0] = 1'b1; b.move = 1'b1; b.bout = 1'b1; end
        end else if (ph == PH_FETCH) begin
            b.irf  = 1'b1;
            b.done = (m_step == STEPS - 1);
        end
        return b;
    endfunction

    int      tnow, flush_t, r16wz_cnt, walu_late;
    int      done_q[$];
    bundle_t hist[0:63];

    task automatic do_cycle(input logic st, input logic [1:0] md, input logic dr,
                            input logic wt, input logic fl);
        i_Start = st; i_Mode = md; i_Dir = dr; i_Wait = wt; i_Flush = fl;
        @(posedge i_Clk);
        model_update(st, md, dr, wt, fl);
        tnow++;
        @(negedge i_Clk);
        chk("cycle", 64'(dut_b), 64'(exp_b()));
        if (tnow < 64) hist[tnow] = dut_b;
        if (dut_b.done) done_q.push_back(tnow);
        if (dut_b.rd16[0]) r16wz_cnt++;
        if (tnow > flush_t && dut_b.walu[0]) walu_late++;
    endtask

    // Cycle k of a run drives inputs for t=k; the start pulse is at t=0.
    task automatic run_seq(input logic [1:0] md, input logic dr, input int wlo, input int whi,
                           input int fat, input int rat, input logic [1:0] md2, input logic dr2,
                           input int n);
        tnow = 0; done_q.delete(); r16wz_cnt = 0; walu_late = 0;
        flush_t = (fat >= 0) ? fat : 1000;
        for (int k = 0; k < n; k++) begin
            logic       st, d;
            logic [1:0] m;
            st = (k == 0) || (k == rat);
            m  = (rat > 0 && k >= rat) ? md2 : md;
            d  = (rat > 0 && k >= rat) ? dr2 : dr;
            do_cycle(st, m, d, (k >= wlo && k <= whi), (k == fat));
        end
    endtask

    function automatic int first_done();
        return (done_q.size() > 0) ? done_q[0] : -1;
    endfunction

    initial begin
        int irf_cnt;
        i_Rst_n = 1'b0; i_Start = 1'b0; i_Mode = 2'b00; i_Dir = 1'b0; i_Wait = 1'b0; i_Flush = 1'b0;
        model_reset();
        tnow = 0; flush_t = 1000;
        repeat (2) @(negedge i_Clk);
        chk("reset_outputs", 64'(dut_b), 64'd0);
        i_Rst_n = 1'b1;

        // (C) store; stray start at t5 with another mode must be ignored.
        run_seq(2'b00, 1'b0, -1, -1, -1, 5, 2'b10, 1'b1, 16);
        chk("c_st_rd8_t1", 64'(hist[1].rd8), 64'h08);
        chk("c_st_b816_t1", 64'(hist[1].b816), 64'd1);
        chk("c_st_data_t5", 64'({hist[5].ralu, hist[5].move, hist[5].bout}), 64'b0111);
        irf_cnt = 0;
        for (int t = 9; t <= 12; t++) irf_cnt += int'(hist[t].irf);
        chk("c_st_irf_cnt", 64'(irf_cnt), 64'd4);
        chk("c_st_done_n", 64'(done_q.size()), 64'd1);
        chk("c_st_done_t", 64'(first_done()), 64'd12);

        // (a8) load
        run_seq(2'b01, 1'b1, -1, -1, -1, -1, 2'b00, 1'b0, 20);
        chk("a8_ld_rd16_t1", 64'(hist[1].rd16), 64'h20);
        chk("a8_ld_inc_t2", 64'(hist[2].inc), 64'd1);
        chk("a8_ld_wr8_t3", 64'({hist[3].wr8, hist[3].bin}), 64'h003);
        chk("a8_ld_rd8_t5", 64'(hist[5].rd8), 64'h01);
        chk("a8_ld_walu_t9", 64'(hist[9].walu), 64'd1);
        chk("a8_ld_done_t", 64'(first_done()), 64'd16);

        // (a16) store, stalled for 3 clocks on ADDR step 0 (t9)
        run_seq(2'b10, 1'b0, 9, 11, -1, -1, 2'b00, 1'b0, 26);
        chk("a16_st_wz_held", 64'(r16wz_cnt), 64'd4);
        chk("a16_st_done_t", 64'(first_done()), 64'd23);

        // (a16) load flushed during DATA, then a normal (C) load
        run_seq(2'b10, 1'b1, -1, -1, 14, -1, 2'b00, 1'b0, 20);
        chk("flush_busy_t15", 64'(hist[15].busy), 64'd0);
        chk("flush_no_done", 64'(done_q.size()), 64'd0);
        chk("flush_no_walu", 64'(walu_late), 64'd0);
        run_seq(2'b00, 1'b1, -1, -1, -1, -1, 2'b00, 1'b0, 14);
        chk("after_flush_walu_t5", 64'(hist[5].walu), 64'd1);
        chk("after_flush_done_t", 64'(first_done()), 64'd12);

        // Back-to-back: start held on the done clock switches to (a8) load
        run_seq(2'b00, 1'b0, -1, -1, -1, 12, 2'b01, 1'b1, 30);
        chk("b2b_done_n", 64'(done_q.size()), 64'd2);
        chk("b2b_done2_t", 64'((done_q.size() > 1) ? done_q[1] : -1), 64'd28);
        chk("b2b_rd16_t13", 64'(hist[13].rd16), 64'h20);

        // Async reset in the middle of ADDR
        run_seq(2'b00, 1'b0, -1, -1, -1, -1, 2'b00, 1'b0, 2);
        #2 i_Rst_n = 1'b0;
        #1 chk("async_rst_out", 64'(dut_b), 64'd0);
        model_reset();
        @(negedge i_Clk);
        repeat (2) do_cycle(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        i_Rst_n = 1'b1;
        repeat (3) do_cycle(1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("rst_release_idle", 64'(o_Busy), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            do_cycle(($urandom_range(3) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
                     ($urandom_range(5) == 0), ($urandom_range(39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
